mdu_iter: RTL
=============

Name: mdu_iter

Overview:
- Iterative multiply/divide unit sitting directly downstream of the main control decoder, beside the single-cycle ALU.
- Consumes the decoder's 6-bit ALU operation code (R-type func encoding) plus both register operands.
- Executes MULT/MULTU/DIV/DIVU over multiple cycles and holds results in architectural HI/LO registers.
- Raises busy so the datapath can stall until done.

Parameters:
- WIDTH, 32, operand width and width of each of HI and LO.
- CNT_W, 6, width of the iteration counter; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request strobe from the control/datapath, sampled on clk.
- alu_op  in  6  operation code in func encoding: MULT 011000, MULTU 011001, DIV 011010, DIVU 011011.
- op_a  in  WIDTH  rs operand (multiplicand or dividend).
- op_b  in  WIDTH  rt operand (multiplier or divisor).
- flush  in  1  synchronous abort of the operation in progress.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse when HI/LO are updated.
- hi  out  WIDTH  HI register: product upper word, or remainder.
- lo  out  WIDTH  LO register: product lower word, or quotient.

Behaviour:
- Reset: asynchronous, active-low; clk is the only clock. While rst_n=0: state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0.
- Reset asserted mid-operation aborts immediately to these values.
- States:
  - IDLE -> CALC when start=1 and alu_op is one of the four valid codes.
  - CALC -> FIX after WIDTH iterations.
  - FIX -> IDLE unconditionally.
- Accept edge: operands are latched on the accepting edge, as magnitudes for signed ops. Sign flags are latched: product sign = a31^b31; quotient sign = a31^b31; remainder sign = a31. busy rises on the same edge.
- Invalid codes: start with any other alu_op is ignored; no busy, no done, hi/lo unchanged.
- Start while busy: ignored; the operation in flight is unaffected.
- CALC: one iteration per cycle, counter counts 0..WIDTH-1.
  - Multiply is shift-add over a 2*WIDTH accumulator.
  - Divide is restoring: shift the remainder left, subtract the divisor, keep the result if it is non-negative, shift a quotient bit in.
- FIX: apply two's-complement sign correction for signed ops, write hi/lo, pulse done=1 for exactly one cycle, drop busy to 0 on the same edge.
- Latency: hi/lo update and done rise exactly WIDTH+1 cycles after the accepting edge (33 for WIDTH=32).
- Back-to-back: a new start is accepted in the cycle done is high, i.e. the first IDLE cycle.
- Divide by zero: runs the normal latency and the data path is not special-cased. Result is lo = all ones, hi = op_a (unsigned view); signed DIV applies the same sign-fix rule. Result is deterministic and no exception is raised.
- Signed overflow, 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0.
- Signed division rounding: quotient truncates toward zero; remainder takes the sign of the dividend.
- flush=1 in CALC or FIX: next state is IDLE, busy=0, no done, hi/lo retain their previous values.
  - flush in IDLE has no effect.
  - flush and start in the same cycle: flush wins and start is ignored.
- hi/lo change only in FIX; they are stable and readable at all other times.

Decomposition:
- Shared package mdu_pkg holds:
  - func-code constants MULT, MULTU, DIV, DIVU; these must match the decoder's encoding.
  - state enum IDLE/CALC/FIX.
  - the WIDTH default.
- One natural sub-module, mdu_sign_fix: combinational conditional two's-complement negate. It is instantiated for operand magnitude at accept and for result correction in FIX.

Test Plan:
- MULT, a=-3 (0xFFFFFFFD), b=7 -> after 33 cycles done pulses once; hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high for exactly 33 cycles.
- MULTU, a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIV, a=-7, b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- DIVU, a=100, b=0 -> lo=0xFFFFFFFF, hi=100, normal latency.
- DIV, a=0x80000000, b=-1 -> lo=0x80000000, hi=0.
- Control cases:
  - start with alu_op=0x20 (ADD) -> no busy.
  - start during busy -> ignored.
  - flush at cycle 10 -> busy drops, no done, hi/lo keep prior values.
  - rst_n low at cycle 5 -> all outputs 0 immediately.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: decoder func codes,
// FSM state encoding and the default operand width.
package mdu_pkg;

  localparam int WIDTH_DEF = 32;

  localparam logic [5:0] MULT  = 6'b011000;
  localparam logic [5:0] MULTU = 6'b011001;
  localparam logic [5:0] DIV   = 6'b011010;
  localparam logic [5:0] DIVU  = 6'b011011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } mdu_state_e;

  function automatic logic op_valid(input logic [5:0] op);
    return (op == MULT) || (op == MULTU) || (op == DIV) || (op == DIVU);
  endfunction

  // Within the four valid codes, bit 1 selects divide and bit 0 selects unsigned.
  function automatic logic op_is_div(input logic [5:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input logic [5:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/mdu_sign_fix.sv
// Conditional two's-complement negate; used for operand magnitudes and result sign fix.
module mdu_sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] val,
  input  logic             neg,
  output logic [WIDTH-1:0] res
);

  assign res = neg ? (~val + WIDTH'(1)) : val;

endmodule

// File: rtl/mdu_iter.sv
// Iterative MULT/MULTU/DIV/DIVU unit: one shift-add or restoring-divide step per
// cycle on unsigned magnitudes, then a single sign-correction cycle into HI/LO.
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [5:0]       alu_op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  mdu_state_e         state;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opnd;
  logic               is_div;
  logic               neg_lo;
  logic               neg_hi;

  logic               accept;
  logic               sgn_op;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [2*WIDTH-1:0] prod_fixed;
  logic [WIDTH-1:0]   quo_fixed;
  logic [WIDTH-1:0]   rem_fixed;

  // acc = {partial product high, multiplier bits still to consume}
  function automatic logic [2*WIDTH-1:0] mul_step(input logic [2*WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0]   m);
    logic [WIDTH:0] sum;
    sum = {1'b0, a[2*WIDTH-1:WIDTH]} + (a[0] ? {1'b0, m} : '0);
    return {sum, a[WIDTH-1:1]};
  endfunction

  // acc = {partial remainder, dividend bits still to consume / quotient bits so far}
  function automatic logic [2*WIDTH-1:0] div_step(input logic [2*WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0]   d);
    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] diff;
    rem_sh = {a[2*WIDTH-1:WIDTH], a[WIDTH-1]};
    diff   = rem_sh - {1'b0, d};
    if (!diff[WIDTH]) return {diff[WIDTH-1:0], a[WIDTH-2:0], 1'b1};
    else              return {rem_sh[WIDTH-1:0], a[WIDTH-2:0], 1'b0};
  endfunction

  assign accept = (state == IDLE) && start && !flush && op_valid(alu_op);
  assign sgn_op = op_is_signed(alu_op);
  assign busy   = (state != IDLE);

  mdu_sign_fix #(.WIDTH(WIDTH)) u_mag_a (
    .val(op_a), .neg(sgn_op & op_a[WIDTH-1]), .res(mag_a)
  );

  mdu_sign_fix #(.WIDTH(WIDTH)) u_mag_b (
    .val(op_b), .neg(sgn_op & op_b[WIDTH-1]), .res(mag_b)
  );

  mdu_sign_fix #(.WIDTH(2*WIDTH)) u_fix_prod (
    .val(acc), .neg(neg_lo), .res(prod_fixed)
  );

  mdu_sign_fix #(.WIDTH(WIDTH)) u_fix_quo (
    .val(acc[WIDTH-1:0]), .neg(neg_lo), .res(quo_fixed)
  );

  mdu_sign_fix #(.WIDTH(WIDTH)) u_fix_rem (
    .val(acc[2*WIDTH-1:WIDTH]), .neg(neg_hi), .res(rem_fixed)
  );

  // Accept: latch magnitudes and result sign flags
  always_ff @(posedge clk) begin
    if (accept) begin
      is_div <= op_is_div(alu_op);
      opnd   <= op_is_div(alu_op) ? mag_b : mag_a;
      acc    <= {{WIDTH{1'b0}}, (op_is_div(alu_op) ? mag_a : mag_b)};
      neg_lo <= sgn_op & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
      neg_hi <= op_is_div(alu_op) ? (sgn_op & op_a[WIDTH-1])
                                  : (sgn_op & (op_a[WIDTH-1] ^ op_b[WIDTH-1]));
    end else if (state == CALC) begin
      acc <= is_div ? div_step(acc, opnd) : mul_step(acc, opnd);
    end
  end

  // Control FSM and architectural HI/LO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state <= CALC;
            cnt   <= '0;
          end
        end
        CALC: begin
          if (flush) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == CNT_W'(WIDTH-1)) begin
            state <= FIX;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        FIX: begin
          state <= IDLE;
          if (!flush) begin
            done <= 1'b1;
            if (is_div) begin
              hi <= rem_fixed;
              lo <= quo_fixed;
            end else begin
              hi <= prod_fixed[2*WIDTH-1:WIDTH];
              lo <= prod_fixed[WIDTH-1:0];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
